// File: rtl/i2s_line_in_rx_pkg.sv
// Shared definitions for the I2S line-in receive path.
//   DataWidthDefault : default sample width captured per channel
//   rx_state_e       : receiver FSM state encoding
//   ChL / ChR        : channel values as carried on the I2S LR clock
package i2s_line_in_rx_pkg;

  localparam int unsigned DataWidthDefault = 24;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } rx_state_e;

  localparam logic ChL = 1'b0;
  localparam logic ChR = 1'b1;

endpackage

// File: rtl/i2s_input_sync.sv
// Input conditioning for the codec I2S pins.
// Each asynchronous pin passes through a SYNC_STAGES-deep synchroniser (SYNC_STAGES >= 2).
// A bclk rising edge produces a one-cycle bedge pulse, with lr_s/data_s registered
// alongside it so all three outputs describe the same bclk edge.
// Ports:
//   clk_100, reset       : system clock, synchronous active-high reset
//   i2s_bclk/lr/data     : raw codec pins (asynchronous)
//   bedge                : one-cycle pulse per bclk rising edge
//   lr_s, data_s         : LR and data values sampled at that edge
module i2s_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_100,
  input  logic reset,
  input  logic i2s_bclk,
  input  logic i2s_lr,
  input  logic i2s_data,
  output logic bedge,
  output logic lr_s,
  output logic data_s
);

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lr_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   bclk_prev_q;
  logic                   bedge_q;
  logic                   lr_q;
  logic                   data_q;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      data_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      bedge_q     <= 1'b0;
      lr_q        <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
      lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], i2s_lr};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i2s_data};
      bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
      bedge_q     <= bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
      lr_q        <= lr_sync_q[SYNC_STAGES-1];
      data_q      <= data_sync_q[SYNC_STAGES-1];
    end
  end

  assign bedge  = bedge_q;
  assign lr_s   = lr_q;
  assign data_s = data_q;

endmodule

// File: rtl/i2s_line_in_rx.sv
// I2S receiver for the ADAU1761 ADC path: deserialises the codec data pin into
// parallel left/right line-in samples on the clk_100 domain.
// Ports:
//   clk_100, reset          : system clock, synchronous active-high reset
//   i2s_bclk/lr/data        : raw codec pins (asynchronous)
//   line_in_l / line_in_r   : last complete L/R pair from one frame, two's complement
//   new_sample              : one-cycle pulse, outputs updated this cycle
//   frame_error             : one-cycle pulse on a short slot
//   locked                  : high once a valid L/R pair has been received
module i2s_line_in_rx
  import i2s_line_in_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DataWidthDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_100,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lr,
  input  logic                  i2s_data,
  output logic [DATA_WIDTH-1:0] line_in_l,
  output logic [DATA_WIDTH-1:0] line_in_r,
  output logic                  new_sample,
  output logic                  frame_error,
  output logic                  locked
);

  localparam int unsigned     CntW    = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  logic bedge;
  logic lr_s;
  logic data_s;

  i2s_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_input_sync (
    .clk_100 (clk_100),
    .reset   (reset),
    .i2s_bclk(i2s_bclk),
    .i2s_lr  (i2s_lr),
    .i2s_data(i2s_data),
    .bedge   (bedge),
    .lr_s    (lr_s),
    .data_s  (data_s)
  );

  rx_state_e             state_q, state_d;
  logic                  channel_q, channel_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_shadow_q, left_shadow_d;
  // Right word complete: publish the pair on the following cycle.
  logic                  load_q, load_d;
  logic                  frame_error_d;
  logic                  boundary;
  logic                  word_done;

  logic [DATA_WIDTH-1:0] line_in_l_q, line_in_r_q;
  logic                  new_sample_q, frame_error_q, locked_q;

  always_comb begin
    state_d       = state_q;
    channel_d     = channel_q;
    lr_prev_d     = lr_prev_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    left_shadow_d = left_shadow_q;
    load_d        = 1'b0;
    frame_error_d = 1'b0;
    word_done     = 1'b0;
    boundary      = bedge && (lr_s != lr_prev_q);

    if (bedge) begin
      lr_prev_d = lr_s;
      unique case (state_q)
        StIdle: begin
          if (boundary && (lr_s == ChL)) begin
            state_d   = StShift;
            channel_d = ChL;
            bit_cnt_d = '0;
          end
        end
        StShift: begin
          if (boundary) begin
            if (bit_cnt_q == LastBit) begin
              // Exact fit: the delayed bit on the boundary is this word's LSB.
              shift_d   = {shift_q[DATA_WIDTH-2:0], data_s};
              word_done = 1'b1;
              channel_d = lr_s;
              bit_cnt_d = '0;
            end else begin
              frame_error_d = 1'b1;
              left_shadow_d = '0;
              channel_d     = ChL;
              bit_cnt_d     = '0;
              state_d       = (lr_s == ChR) ? StIdle : StShift;
            end
          end else begin
            shift_d   = {shift_q[DATA_WIDTH-2:0], data_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
              word_done = 1'b1;
              state_d   = StHold;
            end
          end
          if (word_done) begin
            if (channel_q == ChL) begin
              left_shadow_d = shift_d;
            end else begin
              load_d = 1'b1;
            end
          end
        end
        StHold: begin
          if (boundary) begin
            bit_cnt_d = '0;
            channel_d = lr_s;
            state_d   = StShift;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q       <= StIdle;
      channel_q     <= ChL;
      lr_prev_q     <= 1'b0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      left_shadow_q <= '0;
      load_q        <= 1'b0;
      line_in_l_q   <= '0;
      line_in_r_q   <= '0;
      new_sample_q  <= 1'b0;
      frame_error_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      channel_q     <= channel_d;
      lr_prev_q     <= lr_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      left_shadow_q <= left_shadow_d;
      load_q        <= load_d;
      new_sample_q  <= load_q;
      frame_error_q <= frame_error_d;
      // shift_q cannot move here: bedges are many cycles apart.
      if (load_q) begin
        line_in_l_q <= left_shadow_q;
        line_in_r_q <= shift_q;
        locked_q    <= 1'b1;
      end else if (frame_error_d) begin
        locked_q <= 1'b0;
      end
    end
  end

  assign line_in_l   = line_in_l_q;
  assign line_in_r   = line_in_r_q;
  assign new_sample  = new_sample_q;
  assign frame_error = frame_error_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_i2s_line_in_rx.sv
// Directed bench for i2s_line_in_rx: drives I2S frames and checks the captured pairs.
module tb_i2s_line_in_rx;

  localparam int unsigned DW         = 24;
  localparam int unsigned SyncStages = 2;

  logic          clk_100  = 1'b0;
  logic          reset    = 1'b1;
  logic          i2s_bclk = 1'b0;
  logic          i2s_lr   = 1'b0;
  logic          i2s_data = 1'b0;
  logic [DW-1:0] line_in_l, line_in_r;
  logic          new_sample, frame_error, locked;

  i2s_line_in_rx #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SyncStages)
  ) u_dut (
    .clk_100    (clk_100),
    .reset      (reset),
    .i2s_bclk   (i2s_bclk),
    .i2s_lr     (i2s_lr),
    .i2s_data   (i2s_data),
    .line_in_l  (line_in_l),
    .line_in_r  (line_in_r),
    .new_sample (new_sample),
    .frame_error(frame_error),
    .locked     (locked)
  );

  always #5 clk_100 = ~clk_100;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ns_cnt = 0;
  int fe_cnt = 0;
  int ns_wide = 0;
  int out_glitch = 0;
  int ns_cyc = 0;
  int ns_cyc_prev = 0;
  int last_rise_cyc = 0;
  int lsb_rise_cyc = 0;
  int half = 16;
  logic carry = 1'b0;
  logic sb_en = 1'b0;
  logic ns_prev = 1'b0;
  logic [DW-1:0] l_prev = '0;
  logic [DW-1:0] r_prev = '0;
  logic [2*DW-1:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled 1 ns after each rising clock edge.
  always @(posedge clk_100) begin
    logic [2*DW-1:0] exp_pair;
    cyc++;
    #1;
    if (new_sample) begin
      ns_cnt++;
      ns_cyc_prev = ns_cyc;
      ns_cyc = cyc;
      if (ns_prev) ns_wide++;
      if (sb_en) begin
        exp_pair = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        check_eq("sb_pair", {16'h0, line_in_l, line_in_r}, {16'h0, exp_pair});
      end
    end
    if (frame_error) fe_cnt++;
    if (!new_sample && !reset && ({line_in_l, line_in_r} != {l_prev, r_prev})) out_glitch++;
    ns_prev = new_sample;
    l_prev  = line_in_l;
    r_prev  = line_in_r;
  end

  function automatic logic slot_bit(input logic [DW-1:0] val, input int k);
    return (k < DW) ? val[DW-1-k] : 1'b0;
  endfunction

  // One bclk period; called on a falling clock edge.
  task automatic bclk_cycle(input logic lr, input logic d);
    i2s_bclk = 1'b0;
    i2s_lr   = lr;
    i2s_data = d;
    repeat (half) @(negedge clk_100);
    i2s_bclk = 1'b1;
    last_rise_cyc = cyc;
    repeat (half) @(negedge clk_100);
  endtask

  // One slot of len bclks; data lags lr by one bclk (I2S delay).
  task automatic send_slot(input logic lr, input logic [DW-1:0] val, input int len);
    for (int i = 0; i < len; i++) begin
      bclk_cycle(lr, (i == 0) ? carry : slot_bit(val, i - 1));
      if (lr && (i == DW) && (len > DW)) lsb_rise_cyc = last_rise_cyc;
    end
    carry = slot_bit(val, len - 1);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int len);
    send_slot(1'b0, l, len);
    send_slot(1'b1, r, len);
  endtask

  initial begin
    int ns0, fe0, wide0, glitch0;
    logic [31:0] rnd;
    logic [DW-1:0] l, r;

    repeat (4) @(negedge clk_100);
    check_eq("rst_l", line_in_l, 0);
    check_eq("rst_r", line_in_r, 0);
    check_eq("rst_new_sample", new_sample, 0);
    check_eq("rst_frame_error", frame_error, 0);
    check_eq("rst_locked", locked, 0);
    reset = 1'b0;

    // 1: basic frame after a lead-in right slot
    ns0 = ns_cnt;
    send_slot(1'b1, 24'h0, 32);
    send_frame(24'h123456, 24'hABCDEF, 32);
    check_eq("t1_count", ns_cnt - ns0, 1);
    check_eq("t1_l", line_in_l, 24'h123456);
    check_eq("t1_r", line_in_r, 24'hABCDEF);
    check_eq("t1_locked", locked, 1);
    check_eq("t1_latency", ns_cyc - lsb_rise_cyc - 1, SyncStages + 2);

    // 2: start mid right slot
    reset = 1'b1;
    @(negedge clk_100);
    reset = 1'b0;
    ns0 = ns_cnt;
    send_slot(1'b1, 24'h5A5A5A, 12);
    check_eq("t2_no_early", ns_cnt - ns0, 0);
    check_eq("t2_unlocked", locked, 0);
    send_frame(24'h800000, 24'h7FFFFF, 32);
    check_eq("t2_count", ns_cnt - ns0, 1);
    check_eq("t2_l", line_in_l, 24'h800000);
    check_eq("t2_r", line_in_r, 24'h7FFFFF);
    check_eq("t2_locked", locked, 1);

    // 3: short right slot
    ns0 = ns_cnt;
    fe0 = fe_cnt;
    send_slot(1'b0, 24'h000001, 32);
    send_slot(1'b1, 24'hFFFFFF, 20);
    send_slot(1'b0, 24'h111111, 32);
    check_eq("t3_fe_once", fe_cnt - fe0, 1);
    check_eq("t3_unlocked", locked, 0);
    check_eq("t3_no_sample", ns_cnt - ns0, 0);
    check_eq("t3_keep_l", line_in_l, 24'h800000);
    check_eq("t3_keep_r", line_in_r, 24'h7FFFFF);
    send_slot(1'b1, 24'h222222, 32);
    check_eq("t3_count", ns_cnt - ns0, 1);
    check_eq("t3_relock", locked, 1);
    check_eq("t3_l", line_in_l, 24'h111111);
    check_eq("t3_r", line_in_r, 24'h222222);

    // 4: exact-fit 24-bit slots
    ns0 = ns_cnt;
    fe0 = fe_cnt;
    repeat (3) send_frame(24'hFFFFFF, 24'h000000, 24);
    send_slot(1'b0, 24'h0, 32);
    check_eq("t4_count", ns_cnt - ns0, 3);
    check_eq("t4_no_fe", fe_cnt - fe0, 0);
    check_eq("t4_period", ns_cyc - ns_cyc_prev, 48 * 2 * half);
    check_eq("t4_l", line_in_l, 24'hFFFFFF);
    check_eq("t4_r", line_in_r, 24'h000000);

    // 5: reset 10 bits into a right slot
    ns0 = ns_cnt;
    fork
      send_slot(1'b1, 24'h0F0F0F, 32);
      begin
        repeat (10 * 2 * half + 20) @(negedge clk_100);
        reset = 1'b1;
        @(negedge clk_100);
        reset = 1'b0;
        check_eq("t5_rst_l", line_in_l, 0);
        check_eq("t5_rst_r", line_in_r, 0);
        check_eq("t5_rst_locked", locked, 0);
        check_eq("t5_rst_new_sample", new_sample, 0);
      end
    join
    check_eq("t5_no_sample", ns_cnt - ns0, 0);
    send_frame(24'h0A0A0A, 24'h050505, 32);
    check_eq("t5_count", ns_cnt - ns0, 1);
    check_eq("t5_l", line_in_l, 24'h0A0A0A);
    check_eq("t5_r", line_in_r, 24'h050505);
    check_eq("t5_locked", locked, 1);

    // 6: random stream, faster bclk
    half    = 3;
    ns0     = ns_cnt;
    fe0     = fe_cnt;
    wide0   = ns_wide;
    glitch0 = out_glitch;
    sb_en   = 1'b1;
    for (int f = 0; f < 100; f++) begin
      rnd = $urandom();
      l = rnd[DW-1:0];
      rnd = $urandom();
      r = rnd[DW-1:0];
      send_slot(1'b0, l, 32);
      sb_q.push_back({l, r});
      send_slot(1'b1, r, 32);
    end
    sb_en = 1'b0;
    check_eq("t6_count", ns_cnt - ns0, 100);
    check_eq("t6_no_fe", fe_cnt - fe0, 0);
    check_eq("t6_sb_drained", sb_q.size(), 0);
    check_eq("t6_pulse_width", ns_wide - wide0, 0);
    check_eq("t6_locked", locked, 1);
    check_eq("out_stable", out_glitch - glitch0, 0);
    check_eq("all_pulse_width", ns_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_line_in_rx.md
Name: i2s_line_in_rx

Overview:
- I2S receiver for the ADAU1761 ADC path. It deserialises the codec's serial data pin (AC_GPIO1, the codec-to-FPGA data line) into parallel left/right line-in samples.
- Complements the existing transmit path that serialises hphone_l toward the codec.
- Sits in the top level beside adau1761_codec, on the same clk_100 domain. It replaces the constant-zero line_in_l/line_in_r wires so that line-in audio can feed the echo block and the wave displays.

Parameters:
- DATA_WIDTH, 24: bits captured per channel, MSB first. The rest of each slot is ignored.
- SYNC_STAGES, 2: flops in each input synchroniser. Minimum 2.

Ports:
- clk_100  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high; resets every register
- i2s_bclk  input  1  codec bit clock, about 3.072 MHz, asynchronous to clk_100
- i2s_lr  input  1  codec channel clock; 0 = left, 1 = right; asynchronous
- i2s_data  input  1  codec serial data; asynchronous
- line_in_l  output  DATA_WIDTH  last complete left sample, two's complement
- line_in_r  output  DATA_WIDTH  last complete right sample, two's complement
- new_sample  output  1  one-cycle pulse; line_in_l and line_in_r updated this cycle
- frame_error  output  1  one-cycle pulse; short slot detected
- locked  output  1  high once a valid L/R pair has been received

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the synchroniser and edge-detect flops are cleared. Reset asserted mid-word discards the partial word; there is no new_sample for it. Reset has priority over every other event in the same cycle.
- Input capture:
  - i2s_bclk, i2s_lr and i2s_data each pass through SYNC_STAGES flops.
  - A bclk rising edge ("bedge") is sync_bclk=1 with the previous value 0.
  - On bedge, the synchronised lr and data values are taken as the sampled bit; lr_prev is the lr sampled at the previous bedge.
- Slot boundary: a bedge where the sampled lr differs from lr_prev. The data bit on that edge belongs to the previous slot (the I2S one-bit delay). The next bedge carries the MSB of the new channel.
- FSM states:
  - IDLE: wait for a boundary with lr going 1->0 (start of a left slot), then go to SHIFT with channel=L and bit_cnt=0. Partial slots seen before this are ignored.
  - SHIFT: on each non-boundary bedge, shift data into the shift register (MSB first) and increment bit_cnt. When bit_cnt reaches DATA_WIDTH, go to HOLD.
    - Left slot: copy the shift register into left_shadow.
    - Right slot: load line_in_l from left_shadow and line_in_r from the shift register, and pulse new_sample on the next cycle. locked goes to 1 on that same cycle.
  - HOLD: ignore further bits (slot padding). On a boundary, clear bit_cnt, set channel to the new lr value, and go to SHIFT.
- Short-slot error: a boundary while in SHIFT (fewer than DATA_WIDTH bits received).
  - Pulse frame_error and clear locked.
  - Discard left_shadow; the outputs keep their previous values.
  - Go to IDLE if the new lr is 1. If the new lr is 0, go straight to SHIFT with channel=L.
- Exact-fit slot: a boundary on the bedge immediately after the DATA_WIDTH-th bit is legal, not an error.
- Latency: new_sample asserts SYNC_STAGES+2 clk_100 cycles after raw i2s_bclk first samples high for the right-channel LSB.
- Stable outputs: line_in_l and line_in_r change only in the cycle new_sample is high. The left/right pair is always from the same frame.
- Stalled bclk: no timeout. The FSM holds its state and the outputs hold their values.

Decomposition:
- Shared audio package holds:
  - DATA_WIDTH default (24)
  - FSM state encodings: IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2
  - channel constants: CH_L=1'b0, CH_R=1'b1
- One sub-module, i2s_input_sync: SYNC_STAGES synchroniser for the three pins plus the bclk rising-edge detector. Its outputs are bedge, lr_s and data_s.
- The FSM, shift register, counters and output registers live in the top module.

Test Plan:
Bench conditions: bclk period 32 clk_100 cycles, 64 bclk per frame, 32-bit slots, DATA_WIDTH=24.
1. Send L=24'h123456, R=24'hABCDEF after the first L boundary -> exactly one new_sample; line_in_l=24'h123456, line_in_r=24'hABCDEF; locked=1; new_sample lands SYNC_STAGES+2 cycles after the right LSB bclk high.
2. Start mid-right-slot, then send L=24'h800000, R=24'h7FFFFF -> no new_sample before the first 1->0 lr boundary; afterwards, values captured exactly.
3. Send a right slot of only 20 bits after valid L=24'h000001 -> frame_error pulses once, locked=0, no new_sample, outputs keep their previous pair; the next full frame (L=24'h111111, R=24'h222222) restores locked=1.
4. Use 24-bit exact-fit slots (48 bclk/frame) with L=24'hFFFFFF, R=24'h000000 -> no frame_error; a new_sample pulse every 48 bclk.
5. Assert reset for 1 cycle after 10 bits of a right slot -> all outputs 0 the next cycle, no new_sample for that frame; resumes at the next left boundary.
6. Stream 100 random frames -> the outputs match the scoreboard pair-for-pair, each new_sample is exactly 1 cycle wide, and there are no frame_error pulses.
